// File: rtl/add_seq.sv
// Byte-serial adder: sequences one 8-bit carry-lookahead adder (main) over NBYTES bytes, LSB first.
// Define ADD_SEQ_SUB_EN to add the sub port (a-b, cout=1 means no borrow).

module main (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] p, g;
  logic [8:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is the flattened lookahead term, not a ripple of the previous carry.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 8; i++) begin
      logic term, prod;
      term = g[i];
      prod = p[i];
      for (int unsigned k = 0; k < i; k++) begin
        term = term | (prod & g[i-1-k]);
        prod = prod & p[i-1-k];
      end
      c[i+1] = term | (prod & cin);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

module add_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout
);

  localparam int unsigned IW = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nx;
  logic [NBYTES-1:0][7:0]  a_r, b_r, sum_r;
  logic                    cin_r;
  logic                    carry;
  logic [IW-1:0]           idx;
  logic                    last;
  logic [7:0]              add_a, add_b, add_s;
  logic                    add_ci, add_co;
`ifdef ADD_SEQ_SUB_EN
  logic                    sub_r;
`endif

  assign last = (idx == IW'(NBYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    add_a = a_r[idx];
`ifdef ADD_SEQ_SUB_EN
    // Two's-complement subtract: invert b and force byte-0 carry-in high.
    add_b  = sub_r ? ~b_r[idx] : b_r[idx];
    add_ci = (idx == '0) ? (sub_r | cin_r) : carry;
`else
    add_b  = b_r[idx];
    add_ci = (idx == '0) ? cin_r : carry;
`endif
  end

  main u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_ci),
    .sum  (add_s),
    .cout (add_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      cin_r <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      sum_r <= '0;
      cout  <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      sub_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r   <= a;
          b_r   <= b;
          cin_r <= cin;
          idx   <= '0;
`ifdef ADD_SEQ_SUB_EN
          sub_r <= sub;
`endif
        end
        RUN: begin
          sum_r[idx] <= add_s;
          carry      <= add_co;
          idx        <= idx + IW'(1);
          if (last) cout <= add_co;
        end
        default: ;
      endcase
    end
  end

  assign sum = sum_r;

endmodule

// File: tb/tb_add_seq.sv
// Directed bench for add_seq (NBYTES=4): vector table plus hand-written in-flight, reset-abort and subtract sequences.

module tb_add_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_seq #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef ADD_SEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one operation from IDLE and checks busy length, done pulse and result.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vcin, input logic vsub,
                        input logic [W-1:0] esum, input logic ecout);
    int cycles;
    @(negedge clk);
    a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 64'(cycles), 64'(NB));
    check({name, " done"}, 64'(done), 64'd1);
    check({name, " sum"}, 64'(sum), 64'(esum));
    check({name, " cout"}, 64'(cout), 64'(ecout));
    @(negedge clk);
    check({name, " done_drop"}, 64'(done), 64'd0);
    check({name, " sum_hold"}, 64'(sum), 64'(esum));
  endtask

  initial begin
    vec_t vecs[7];
    int   ndone;
    int   cyc;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 32'h0001_FFFF, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{32'h00FF_FF00, 32'h0000_0100, 1'b0, 32'h0100_0000, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sum",  64'(sum),  64'd0);
    check("reset cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
             vecs[i].sum, vecs[i].cout);

    // Inputs and start toggled mid-operation must not disturb the accepted operands.
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; cin = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1 || i == 3) start = 1'b1;
      else                  start = 1'b0;
      if (done) ndone++;
      @(negedge clk);
    end
    start = 1'b0;
    check("inflight done_count", 64'(ndone), 64'd1);
    check("inflight sum", 64'(sum), 64'h2345_678A);
    check("inflight cout", 64'(cout), 64'd0);
    repeat (12) @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse.
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort sum",  64'(sum),  64'd0);
    check("abort cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    cyc = 0;
    repeat (8) begin
      if (done) ndone++;
      if (busy) cyc++;
      @(negedge clk);
    end
    check("abort no_done", 64'(ndone), 64'd0);
    check("abort no_busy", 64'(cyc), 64'd0);
    run_op("after_abort", 32'd3, 32'd4, 1'b0, 1'b0, 32'h0000_0007, 1'b0);

`ifdef ADD_SEQ_SUB_EN
    run_op("sub 7-5", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
    run_op("sub 5-7", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_op("add after sub", 32'd5, 32'd7, 1'b0, 1'b0, 32'h0000_000C, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
